// File: rtl/vga_fb_scheduler.sv
// Frame-buffer port scheduler for VGA_gen: scan-out prefetch, clear sequencer
// and drawing-engine writes sharing one single-port RAM.
module vga_fb_scheduler #(
  parameter int                   FB_W       = 160,
  parameter int                   FB_H       = 120,
  parameter int                   COLOR_W    = 8,
  parameter int                   ADDR_W     = 15,
  parameter int                   H_ACTIVE   = 640,
  parameter int                   H_PREFETCH = 788,
  parameter int                   V_LAST     = 525,
  parameter logic [COLOR_W-1:0]   CLR_COLOR  = '0
) (
  input  logic               VGA_clk,
  input  logic               rst,
  input  logic [9:0]         xPixel,
  input  logic [9:0]         yPixel,
  input  logic               displayArea,
  output logic [COLOR_W-1:0] pix_color,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  input  logic               wr_req,
  input  logic [7:0]         wr_x,
  input  logic [6:0]         wr_y,
  input  logic [COLOR_W-1:0] wr_color,
  output logic               wr_ack,
  output logic               wr_drop,
  input  logic               clr_req,
  output logic               clr_busy,
  output logic               frame_start
);

  localparam int                FB_SIZE    = FB_W * FB_H;
  localparam logic [9:0]        X_LINE_END = 10'(H_ACTIVE - 4);
  localparam logic [9:0]        X_ACTIVE   = 10'(H_ACTIVE);
  localparam logic [9:0]        Y_ACTIVE   = 10'(4 * FB_H);
  localparam logic [9:0]        X_PREFETCH = 10'(H_PREFETCH);
  localparam logic [9:0]        Y_LAST     = 10'(V_LAST);
  localparam logic [9:0]        FB_W10     = 10'(FB_W);
  localparam logic [9:0]        FB_H10     = 10'(FB_H);
  localparam logic [ADDR_W-1:0] CLR_LAST   = ADDR_W'(FB_SIZE - 1);

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  clr_state_t          state, state_nx;
  logic [ADDR_W-1:0]   clr_addr;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   fetch_addr;
  logic [ADDR_W-1:0]   wr_addr;
  logic [9:0]          next_row;
  logic                fetch_line, fetch_pre, fetch_slot, fetch_d;
  logic                clr_write;
  logic                wr_in_range;
  logic                display_next;
  logic [COLOR_W-1:0]  next_pix;

  // Linear address with one spare bit of headroom before truncation.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [9:0] row,
                                                 input logic [9:0] col);
    logic [ADDR_W:0] p;
    p = (ADDR_W+1)'(row) * (ADDR_W+1)'(FB_W) + (ADDR_W+1)'(col);
    return p[ADDR_W-1:0];
  endfunction

  always_comb begin
    next_row     = (yPixel == Y_LAST) ? '0 : ((yPixel + 10'd1) >> 2);
    fetch_line   = (xPixel[1:0] == 2'b00) && (xPixel < X_LINE_END);
    fetch_pre    = (xPixel == X_PREFETCH);
    fetch_slot   = fetch_line || fetch_pre;
    fetch_addr   = fetch_pre ? lin_addr(next_row, 10'd0)
                             : lin_addr({2'b00, yPixel[9:2]}, {2'b00, xPixel[9:2]} + 10'd1);
    wr_addr      = lin_addr({3'b000, wr_y}, {2'b00, wr_x});
    wr_in_range  = ({2'b00, wr_x} < FB_W10) && ({3'b000, wr_y} < FB_H10);
    display_next = (xPixel < X_ACTIVE) && (yPixel < Y_ACTIVE);
    clr_write    = (state == CLEAR) && !fetch_slot;
  end

  // Clear FSM: state register (clr_addr advances alongside it).
  always_ff @(posedge VGA_clk) begin
    if (rst) begin
      state    <= IDLE;
      clr_addr <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && clr_req)
        clr_addr <= '0;
      else if (clr_write)
        clr_addr <= clr_addr + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (clr_req) state_nx = CLEAR;
      CLEAR:   if (clr_write && clr_addr == CLR_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Port arbitration: fetch > clear > drawing write. Idle cycles replay addr_q.
  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    wr_ack    = 1'b0;
    wr_drop   = 1'b0;
    clr_busy  = (state == CLEAR);
    if (rst) begin
      mem_addr = '0;
      clr_busy = 1'b0;
    end else if (fetch_slot) begin
      mem_addr = fetch_addr;
    end else if (state == CLEAR) begin
      mem_addr  = clr_addr;
      mem_we    = 1'b1;
      mem_wdata = CLR_COLOR;
    end else if (clr_req) begin
      mem_addr = addr_q;
    end else if (wr_req) begin
      wr_ack = 1'b1;
      if (wr_in_range) begin
        mem_addr  = wr_addr;
        mem_we    = 1'b1;
        mem_wdata = wr_color;
      end else begin
        wr_drop = 1'b1;
      end
    end
  end

  // Scan-out: next_pix is one column ahead; pix_color updates every 4th pixel
  // one cycle late, lining up with the registered displayArea.
  always_ff @(posedge VGA_clk) begin
    if (rst) begin
      addr_q      <= '0;
      fetch_d     <= 1'b0;
      next_pix    <= '0;
      pix_color   <= '0;
      frame_start <= 1'b0;
    end else begin
      addr_q      <= mem_addr;
      fetch_d     <= fetch_slot;
      frame_start <= (xPixel == 10'd0) && (yPixel == 10'd0);
      if (fetch_d)
        next_pix <= mem_rdata;
      if (xPixel[1:0] == 2'b00)
        pix_color <= display_next ? next_pix : '0;
      else if (!displayArea && !display_next)
        pix_color <= '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed self-checking bench for vga_fb_scheduler with a behavioural
// synchronous-read RAM and software-driven VGA counters.
module tb_vga_fb_scheduler;

  logic        VGA_clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  xPixel = '0;
  logic [9:0]  yPixel = '0;
  logic        displayArea = 1'b0;
  logic [7:0]  pix_color;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        wr_req = 1'b0;
  logic [7:0]  wr_x = '0;
  logic [6:0]  wr_y = '0;
  logic [7:0]  wr_color = '0;
  logic        wr_ack;
  logic        wr_drop;
  logic        clr_req = 1'b0;
  logic        clr_busy;
  logic        frame_start;

  always #5 VGA_clk = ~VGA_clk;

  vga_fb_scheduler #(
    .FB_W(160), .FB_H(120), .COLOR_W(8), .ADDR_W(15),
    .H_ACTIVE(640), .H_PREFETCH(788), .V_LAST(525), .CLR_COLOR(8'h00)
  ) dut (
    .VGA_clk(VGA_clk), .rst(rst), .xPixel(xPixel), .yPixel(yPixel),
    .displayArea(displayArea), .pix_color(pix_color), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .wr_ack(wr_ack), .wr_drop(wr_drop), .clr_req(clr_req),
    .clr_busy(clr_busy), .frame_start(frame_start)
  );

  logic [7:0] ram [0:32767];
  logic       fill = 1'b1;

  always @(posedge VGA_clk) begin
    if (fill) begin
      for (int i = 0; i < 32768; i++) ram[i] <= 8'(i);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  int         n_checks = 0;
  int         n_fail = 0;
  int         cx = 300, cy = 100;
  logic       act_prev = 1'b0;
  logic       q_rst = 1'b1, q_wr_req = 1'b0, q_clr = 1'b0;
  logic [7:0] q_wx = '0;
  logic [6:0] q_wy = '0;
  logic [7:0] q_wc = '0;
  logic [7:0] seen [0:799];
  logic       fs_seen [0:799];
  int         nwe;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge VGA_clk); #1;
    rst         = q_rst;
    xPixel      = 10'(cx);
    yPixel      = 10'(cy);
    displayArea = act_prev;
    act_prev    = (cx < 640) && (cy < 480);
    wr_req      = q_wr_req;
    wr_x        = q_wx;
    wr_y        = q_wy;
    wr_color    = q_wc;
    clr_req     = q_clr;
    #1;
  endtask

  task automatic adv();
    if (cx == 799) begin
      cx = 0;
      cy = (cy == 525) ? 0 : cy + 1;
    end else begin
      cx++;
    end
    step();
  endtask

  task automatic scan(input int y, input int x0, input int x1);
    cy = y; cx = x0;
    step();
    seen[cx] = pix_color; fs_seen[cx] = frame_start;
    if (mem_we) nwe++;
    while (cx < x1) begin
      adv();
      seen[cx] = pix_color; fs_seen[cx] = frame_start;
      if (mem_we) nwe++;
    end
  endtask

  initial begin
    int nwr, nack, bad, k;
    logic done, got;

    // Reset held mid-line on a fetch slot with a write pending.
    q_wr_req = 1'b1; q_wx = 8'd5; q_wy = 7'd2; q_wc = 8'h3C;
    step(); fill = 1'b0;
    step(); step();
    check_eq("rst_pix", pix_color, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_ack", {wr_ack, wr_drop}, 0);
    check_eq("rst_busy", clr_busy, 0);
    check_eq("rst_fs", frame_start, 0);
    q_rst = 1'b0; q_wr_req = 1'b0;

    // Scan-out of RAM[a]=a[7:0]; pix_color at xPixel x shows screen x-1.
    nwe = 0;
    scan(525, 780, 799);
    scan(0, 0, 799);
    check_eq("fs_before", fs_seen[0], 0);
    check_eq("fs_pulse", fs_seen[1], 1);
    check_eq("fs_after", fs_seen[2], 0);
    check_eq("pix_x0", seen[1], 8'h00);
    check_eq("pix_x3", seen[4], 8'h00);
    check_eq("pix_x4", seen[5], 8'h01);
    check_eq("pix_x7", seen[8], 8'h01);
    check_eq("pix_x8", seen[9], 8'h02);
    check_eq("pix_x639", seen[640], 8'h9F);
    check_eq("pix_x640", seen[641], 8'h00);
    check_eq("pix_x700", seen[701], 8'h00);
    scan(3, 780, 799);
    scan(4, 0, 10);
    check_eq("pix_y4_x0", seen[1], 8'hA0);
    check_eq("pix_y4_x4", seen[5], 8'hA1);
    check_eq("scan_no_we", nwe, 0);

    // Write contention around a fetch slot, then back-to-back and out-of-range.
    q_wr_req = 1'b1; q_wx = 8'd5; q_wy = 7'd2; q_wc = 8'h3C;
    cx = 100; cy = 8; step();
    check_eq("wc_fetch_ack", wr_ack, 0);
    check_eq("wc_fetch_we", mem_we, 0);
    check_eq("wc_fetch_addr", mem_addr, 346);
    adv();
    check_eq("wc_ack", {wr_ack, wr_drop}, 2'b10);
    check_eq("wc_we", mem_we, 1);
    check_eq("wc_addr", mem_addr, 325);
    check_eq("wc_wdata", mem_wdata, 8'h3C);
    q_wx = 8'd10; q_wy = 7'd0; q_wc = 8'h55; adv();
    check_eq("b2b_ack", wr_ack, 1);
    check_eq("b2b_addr", mem_addr, 10);
    q_wx = 8'd159; q_wy = 7'd119; q_wc = 8'hAB; adv();
    check_eq("corner_ack", {wr_ack, mem_we}, 2'b11);
    check_eq("corner_addr", mem_addr, 19199);
    q_wx = 8'd160; q_wy = 7'd0; adv();
    check_eq("oor_x_stall", wr_ack, 0);
    adv();
    check_eq("oor_x", {wr_ack, wr_drop, mem_we}, 3'b110);
    q_wx = 8'd0; q_wy = 7'd120; adv();
    check_eq("oor_y", {wr_ack, wr_drop, mem_we}, 3'b110);
    q_wr_req = 1'b0; adv();
    check_eq("ram_325", ram[325], 8'h3C);
    check_eq("ram_10", ram[10], 8'h55);
    check_eq("ram_19199", ram[19199], 8'hAB);

    // Full clear with a write held throughout.
    q_wr_req = 1'b1; q_wx = 8'd7; q_wy = 7'd3; q_wc = 8'h77; q_clr = 1'b1;
    adv();
    check_eq("clr_start_ack", wr_ack, 0);
    check_eq("clr_start_busy", clr_busy, 0);
    q_clr = 1'b0;
    nwr = 0; nack = 0; done = 1'b0;
    for (int i = 0; i < 40000 && !done; i++) begin
      adv();
      if (clr_busy) begin
        if (mem_we) nwr++;
        if (wr_ack) nack++;
      end else begin
        done = 1'b1;
      end
    end
    check_eq("clr_done", done, 1);
    check_eq("clr_writes", nwr, 19200);
    check_eq("clr_no_ack", nack, 0);
    got = 1'b0; k = 0;
    while (k < 3 && !got) begin
      if (wr_ack) begin
        got = 1'b1;
        check_eq("held_addr", mem_addr, 487);
        check_eq("held_we", mem_we, 1);
      end else begin
        adv(); k++;
      end
    end
    check_eq("held_ack", got, 1);
    check_eq("held_latency_ok", (k <= 1), 1);
    q_wr_req = 1'b0; adv();
    bad = 0;
    for (int a = 0; a < 19200; a++)
      if (a != 487 && ram[a] !== 8'h00) bad++;
    check_eq("clr_cells", bad, 0);
    check_eq("clr_held_cell", ram[487], 8'h77);
    check_eq("clr_beyond", ram[19201], 8'h01);
    scan(11, 780, 799);
    scan(12, 0, 40);
    check_eq("post_clr_x0", seen[1], 8'h00);
    check_eq("post_clr_x24", seen[25], 8'h00);
    check_eq("post_clr_x28", seen[29], 8'h77);
    check_eq("post_clr_x31", seen[32], 8'h77);
    check_eq("post_clr_x32", seen[33], 8'h00);

    // Reset after 5000 clear writes.
    fill = 1'b1; adv(); fill = 1'b0;
    q_clr = 1'b1; adv(); q_clr = 1'b0;
    nwr = 0;
    for (int i = 0; i < 10000 && nwr < 5000; i++) begin
      adv();
      if (clr_busy && mem_we) nwr++;
    end
    check_eq("mid_writes", nwr, 5000);
    q_rst = 1'b1; adv();
    check_eq("mid_rst_busy", clr_busy, 0);
    check_eq("mid_rst_we", mem_we, 0);
    adv(); q_rst = 1'b0;
    adv(); adv(); adv();
    check_eq("mid_after_busy", clr_busy, 0);
    check_eq("mid_ram_4999", ram[4999], 8'h00);
    check_eq("mid_ram_5000", ram[5000], 8'h88);
    bad = 0;
    for (int a = 5000; a < 19200; a++)
      if (ram[a] !== 8'(a)) bad++;
    check_eq("mid_untouched", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
